regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between NUM_REQ requesters (ALU writeback, load writeback, link-register write, debug/test port).
- Round-robin arbitration with optional short burst lock.
- Drives one registered write port (address, enable, data) that feeds the 5-to-32 write-enable decoder and register array.
- Suppresses writes to the hardwired zero register (X31).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 64, register data width
ADDR_WIDTH, 5, register address width (32 registers)
MAX_BURST, 4, maximum consecutive grants to a locked owner

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester write request
req_lock  input  NUM_REQ  requester asks to keep grant for following cycles
req_addr  input  NUM_REQ*ADDR_WIDTH  packed destination register, requester i at [i*5 +: 5]
req_data  input  NUM_REQ*DATA_WIDTH  packed write data, requester i at [i*64 +: 64]
req_ready  output  NUM_REQ  one-hot handshake; transfer when valid&ready
freeze  input  1  blocks all new grants (pipeline stall / test mode)
wr_en  output  1  write enable to decoder enable
wr_addr  output  ADDR_WIDTH  write register index to decoder select
wr_data  output  DATA_WIDTH  write data to register array
wr_src  output  $clog2(NUM_REQ)  index of the requester that produced the current write
zero_drop  output  1  one-cycle pulse: the accepted request targeted X31 and was discarded

Behaviour:
- Clock and reset: one clock `clk`. Reset is asynchronous and active-low on `reset_n`.
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0, wr_src=0, zero_drop=0.
  - RR pointer=0, state=ARB, burst count=0.
  - req_ready is all 0 while reset_n=0.
- Handshake:
  - req_ready is combinational from req_valid, pointer, state and freeze.
  - At most one bit is set, and only on a requester with valid=1.
  - Requesters hold addr/data stable until ready.
- Latency: a request accepted in cycle N appears on wr_en/wr_addr/wr_data/wr_src in cycle N+1, for exactly one cycle. This gives 1 write per cycle sustained.
- ARB state:
  - Grant the first valid requester at or after the pointer, wrapping modulo NUM_REQ.
  - After a grant to i, pointer <= (i+1) mod NUM_REQ. No grant leaves the pointer unchanged.
  - If the granted i also has req_lock=1 and MAX_BURST>1: go to LOCKED with owner<=i and burst<=1.
- LOCKED state:
  - Only the owner is eligible.
  - Each owner grant increments burst.
  - Return to ARB when any of these holds: the owner's valid=0, the owner's lock=0 on a granted cycle, or burst reaches MAX_BURST.
  - On exit, pointer = owner+1, so other requesters are never starved.
  - Worst-case wait for a continuously-valid requester: (NUM_REQ-1)*MAX_BURST+1 cycles.
- freeze=1:
  - req_ready all 0.
  - Next-cycle wr_en=0.
  - Pointer, state and burst hold.
  - freeze does not cancel a write already registered.
- Zero register: an accepted request with addr=31 completes its handshake, but next cycle wr_en=0 and zero_drop=1. wr_addr/wr_data/wr_src still update for trace.
- Idle: with no valid requests, wr_en=0 next cycle and wr_addr/wr_data hold their last values.
- Reset mid-operation:
  - Asynchronous clear of all state.
  - A registered write is lost and not replayed.
  - The requester sees no ready and must re-present after reset.
- Width rules:
  - The pointer wraps at NUM_REQ, not at the power of two.
  - Burst counter width is $clog2(MAX_BURST+1) and saturates at MAX_BURST.

Decomposition:
- Package regfile_pkg contains:
  - REG_ADDR_W=5, NUM_REGS=32, ZERO_REG=5'd31, REG_DATA_W=64.
  - typedef enum logic {ARB, LOCKED} wr_arb_state_t.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any.
  - It is reused in LOCKED mode with the request vector masked to the owner.

Test Plan:
- Reset with all valid=1, reset_n=0 → req_ready=0000, wr_en=0. After release, first grant is requester 0 and wr_en=1 the next cycle with wr_src=0.
- req_valid=1111, no locks, for 8 cycles → grants 0,1,2,3,0,1,2,3. Each write appears one cycle later with matching addr/data, e.g. req 2 addr=5'd7, data=64'hA5 → wr_addr=7, wr_data=64'hA5.
- Requester 1 valid+lock continuously, others valid → requester 1 gets 4 consecutive grants, then requesters 2,3,0 each get one, then requester 1 again.
- Requester 3 alone, addr=31, data=64'hFFFF → ready=1, next cycle wr_en=0 and zero_drop=1. Following request addr=30 → wr_en=1, wr_addr=30.
- freeze=1 for 3 cycles with all valid → no ready and wr_en=0 after the first cycle. Pointer unchanged, so the grant after freeze=0 goes to the requester that was next before the freeze.
- Assert reset_n=0 asynchronously mid-cycle while LOCKED with wr_en=1 → wr_en drops immediately (before the next edge) and state returns to ARB with pointer 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-arbiter state type.
package regfile_pkg;

  localparam int         REG_ADDR_W = 5;
  localparam int         NUM_REGS   = 32;
  localparam logic [4:0] ZERO_REG   = 5'd31;
  localparam int         REG_DATA_W = 64;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } wr_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping at N (not at the next power of two).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan the N candidates starting at ptr and keep only the first hit.
  always_comb begin
    logic [IW:0]   raw;
    logic [IW:0]   wrapped;
    logic [IW-1:0] cand;
    logic          hit;
    gnt     = '0;
    idx     = '0;
    any     = 1'b0;
    raw     = '0;
    wrapped = '0;
    cand    = '0;
    hit     = 1'b0;
    for (int k = 0; k < N; k++) begin
      raw       = {1'b0, ptr} + (IW+1)'(k);
      wrapped   = (raw >= (IW+1)'(N)) ? (raw - (IW+1)'(N)) : raw;
      cand      = wrapped[IW-1:0];
      hit       = ~any & req[cand];
      gnt[cand] = gnt[cand] | hit;
      idx       = hit ? cand : idx;
      any       = any | hit;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between NUM_REQ requesters
// using round-robin arbitration with an optional short burst lock. Writes
// aimed at the hardwired zero register are accepted but not performed.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          freeze,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    wr_src,
  output logic                          zero_drop
);

  localparam int IW      = $clog2(NUM_REQ);
  localparam int BW      = $clog2(MAX_BURST + 1);
  localparam bit LOCK_EN = (MAX_BURST > 1);

  // Pointer increment that wraps at NUM_REQ.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    wrap_inc = (v == IW'(NUM_REQ - 1)) ? '0 : (v + IW'(1));
  endfunction

  wr_arb_state_t           state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           owner_q, owner_d;
  logic [BW-1:0]           burst_q, burst_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic [IW-1:0]           wr_src_q, wr_src_d;
  logic                    zero_drop_q, zero_drop_d;

  logic [NUM_REQ-1:0]      owner_mask_s;
  logic [NUM_REQ-1:0]      pick_req_s;
  logic [NUM_REQ-1:0]      pick_gnt_s;
  logic [IW-1:0]           pick_idx_s;
  logic                    pick_any_s;
  logic [NUM_REQ-1:0]      grant_s;
  logic                    accept_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;

  // Restrict eligibility to the owner while a burst lock is held.
  always_comb begin
    owner_mask_s          = '0;
    owner_mask_s[owner_q] = 1'b1;
    pick_req_s            = (state_q == LOCKED) ? (req_valid & owner_mask_s) : req_valid;
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (pick_req_s),
    .ptr (ptr_q),
    .gnt (pick_gnt_s),
    .idx (pick_idx_s),
    .any (pick_any_s)
  );

  // Final grant: nothing while frozen or in reset; select the winner's payload.
  always_comb begin
    grant_s    = (freeze || !reset_n) ? '0 : pick_gnt_s;
    accept_s   = |grant_s;
    sel_addr_s = req_addr[pick_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
    sel_data_s = req_data[pick_idx_s*DATA_WIDTH +: DATA_WIDTH];
  end

  assign req_ready = grant_s;

  // Arbitration FSM next state: pointer, lock owner and burst count.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    burst_d = burst_q;
    if (freeze) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ARB: begin
          if (pick_any_s) begin
            ptr_d = wrap_inc(pick_idx_s);
            if (LOCK_EN && req_lock[pick_idx_s]) begin
              state_d = LOCKED;
              owner_d = pick_idx_s;
              burst_d = BW'(1);
            end else begin
              state_d = ARB;
            end
          end else begin
            state_d = ARB;
          end
        end
        LOCKED: begin
          // Exiting always moves the pointer past the owner so nobody starves.
          if (pick_any_s && req_lock[owner_q] && ((burst_q + BW'(1)) < BW'(MAX_BURST))) begin
            burst_d = burst_q + BW'(1);
          end else begin
            state_d = ARB;
            ptr_d   = wrap_inc(owner_q);
            burst_d = '0;
          end
        end
        default: begin
          state_d = ARB;
          ptr_d   = '0;
          burst_d = '0;
        end
      endcase
    end
  end

  // Next write-port contents; the zero register is traced but never written.
  always_comb begin
    wr_en_d     = 1'b0;
    zero_drop_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_src_d    = wr_src_q;
    if (accept_s) begin
      wr_en_d     = (sel_addr_s != ADDR_WIDTH'(ZERO_REG));
      zero_drop_d = (sel_addr_s == ADDR_WIDTH'(ZERO_REG));
      wr_addr_d   = sel_addr_s;
      wr_data_d   = sel_data_s;
      wr_src_d    = pick_idx_s;
    end else begin
      wr_en_d     = 1'b0;
      zero_drop_d = 1'b0;
    end
  end

  // State and write-port registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      burst_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_src_q    <= '0;
      zero_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      burst_q     <= burst_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_src_q    <= wr_src_d;
      zero_drop_q <= zero_drop_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_src    = wr_src_q;
  assign zero_drop = zero_drop_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_regfile_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid, req_lock, req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic              freeze, wr_en, zero_drop;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [1:0]        wr_src;

  logic [AW-1:0]     a_arr [N];
  logic [DW-1:0]     d_arr [N];

  int n_chk  = 0;
  int n_fail = 0;

  regfile_write_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_lock(req_lock),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .freeze(freeze), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_src(wr_src), .zero_drop(zero_drop)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a_arr[i];
      req_data[i*DW +: DW] = d_arr[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who wins this cycle, and what the write port shows next.
  int            m_ptr, m_owner, m_burst, g;
  bit            m_locked;
  logic          m_en, m_zd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_src;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_ptr = 0; m_owner = 0; m_burst = 0; m_locked = 0;
      m_en = 1'b0; m_zd = 1'b0; m_addr = '0; m_data = '0; m_src = 0;
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_wr_en", 64'(wr_en), 64'd0);
      chk("rst_zero_drop", 64'(zero_drop), 64'd0);
    end else begin
      chk("m_wr_en", 64'(wr_en), 64'(m_en));
      chk("m_zero_drop", 64'(zero_drop), 64'(m_zd));
      chk("m_wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("m_wr_data", wr_data, m_data);
      chk("m_wr_src", 64'(wr_src), 64'(m_src));
      g = -1;
      if (!freeze) begin
        if (m_locked) begin
          if (((req_valid >> m_owner) & 4'd1) != 4'd0) g = m_owner;
        end else begin
          for (int k = 0; k < N; k++)
            if (g < 0 && ((req_valid >> ((m_ptr + k) % N)) & 4'd1) != 4'd0) g = (m_ptr + k) % N;
        end
      end
      chk("m_req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
      m_en = 1'b0;
      m_zd = 1'b0;
      if (g >= 0) begin
        m_addr = a_arr[g];
        m_data = d_arr[g];
        m_src  = g;
        m_en   = (a_arr[g] != 5'd31);
        m_zd   = (a_arr[g] == 5'd31);
      end
      if (!freeze) begin
        if (m_locked) begin
          if (g < 0) begin
            m_locked = 0; m_ptr = (m_owner + 1) % N; m_burst = 0;
          end else begin
            m_burst++;
            if (((req_lock >> m_owner) & 4'd1) == 4'd0 || m_burst >= MB) begin
              m_locked = 0; m_ptr = (m_owner + 1) % N; m_burst = 0;
            end
          end
        end else if (g >= 0) begin
          m_ptr = (g + 1) % N;
          if (((req_lock >> g) & 4'd1) != 4'd0 && MB > 1) begin
            m_locked = 1; m_owner = g; m_burst = 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int lock_seq [9] = '{0, 1, 1, 1, 1, 2, 3, 0, 1};

  initial begin
    reset_n = 1'b0; freeze = 1'b0; req_valid = 4'b1111; req_lock = 4'b0000;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = AW'(i + 5);
      d_arr[i] = 64'h10 + 64'(i);
    end
    d_arr[2] = 64'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_wr_en", 64'(wr_en), 64'd0);
    chk("reset_wr_addr", 64'(wr_addr), 64'd0);
    chk("reset_wr_data", wr_data, 64'd0);
    chk("reset_wr_src", 64'(wr_src), 64'd0);
    tick();
    reset_n = 1'b1;

    // Plain round robin: 0,1,2,3,0,1,2,3 with one-cycle write latency.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_ready", 64'(req_ready), 64'd1 << (k % 4));
      if (k > 0) begin
        chk("rr_wr_en", 64'(wr_en), 64'd1);
        chk("rr_wr_src", 64'(wr_src), 64'((k - 1) % 4));
      end
      if (k == 3) begin
        chk("rr_wr_addr", 64'(wr_addr), 64'd7);
        chk("rr_wr_data", wr_data, 64'hA5);
      end
      tick();
    end

    // Burst lock on requester 1.
    req_lock = 4'b0010;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      chk("lock_ready", 64'(req_ready), 64'd1 << lock_seq[j]);
      tick();
    end

    // Idle: no grants, write port holds last address/data.
    req_valid = 4'b0000; req_lock = 4'b0000;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("idle_ready", 64'(req_ready), 64'd0);
    chk("idle_wr_en", 64'(wr_en), 64'd0);
    chk("idle_wr_addr", 64'(wr_addr), 64'd6);
    chk("idle_wr_data", wr_data, 64'h11);
    tick();

    // Zero-register drop, then a normal write.
    req_valid = 4'b1000; a_arr[3] = 5'd31; d_arr[3] = 64'hFFFF;
    @(negedge clk);
    chk("zero_ready", 64'(req_ready), 64'd8);
    tick();
    a_arr[3] = 5'd30;
    @(negedge clk);
    chk("zero_wr_en", 64'(wr_en), 64'd0);
    chk("zero_drop", 64'(zero_drop), 64'd1);
    chk("zero_wr_addr", 64'(wr_addr), 64'd31);
    chk("zero_wr_data", wr_data, 64'hFFFF);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("r30_wr_en", 64'(wr_en), 64'd1);
    chk("r30_wr_addr", 64'(wr_addr), 64'd30);
    chk("r30_zero_drop", 64'(zero_drop), 64'd0);
    tick();

    // Freeze for three cycles; the pointer must survive it.
    req_valid = 4'b1111;
    @(negedge clk);
    chk("prefrz_ready", 64'(req_ready), 64'd1);
    tick();
    freeze = 1'b1;
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      chk("frz_ready", 64'(req_ready), 64'd0);
      chk("frz_wr_en", 64'(wr_en), (f == 0) ? 64'd1 : 64'd0);
      tick();
    end
    freeze = 1'b0; req_lock = 4'b0010;
    @(negedge clk);
    chk("unfrz_ready", 64'(req_ready), 64'd2);
    tick();

    // Asynchronous reset while locked with a write on the port.
    #1;
    chk("lkrst_pre_wr_en", 64'(wr_en), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("lkrst_wr_en", 64'(wr_en), 64'd0);
    chk("lkrst_ready", 64'(req_ready), 64'd0);
    tick();
    req_lock = 4'b0000;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("lkrst_ptr0_ready", 64'(req_ready), 64'd1);
    tick();

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_lock  = 4'($urandom_range(0, 15));
      freeze    = ($urandom_range(0, 9) == 0);
      reset_n   = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < N; i++) begin
        a_arr[i] = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
        d_arr[i] = {32'($urandom), 32'($urandom)};
      end
      tick();
    end
    reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
